gpio_ctrl: RTL and testbench
============================

GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of GPIO lines (1..32).
REQ-002 SHALL have port clk  input  1  system clock; all flops on rising edge.
REQ-003 SHALL have port rstn  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port bus_req  input  1  one-cycle access strobe from core bus.
REQ-005 SHALL have port bus_we  input  1  1 = write, 0 = read; qualified by bus_req.
REQ-006 SHALL have port bus_addr  input  4  word-register index.
REQ-007 SHALL have port bus_wdata  input  32  write data; bits above WIDTH ignored.
REQ-008 SHALL have port bus_rdata  output  32  read data; valid while bus_ack=1, else 0.
REQ-009 SHALL have port bus_ack  output  1  response strobe, one cycle after each bus_req.
REQ-010 SHALL have port gpio_in  input  WIDTH  asynchronous pad inputs.
REQ-011 SHALL have port gpio_out  output  WIDTH  output data to pad tristate.
REQ-012 SHALL have port gpio_en  output  WIDTH  output enable per pad, 1 = drive.
REQ-013 SHALL have port irq  output  1  level interrupt = OR of enabled pending bits.

Function
REQ-014 Register map (index: name, access) SHALL be: 0 OUT rw; 1 DIR rw; 2 IN ro; 3 SET wo; 4 CLR wo; 5 TGL wo; 6 RISE_EN rw; 7 FALL_EN rw; 8 PEND rw1c; 9-15 reserved.
REQ-015 gpio_out SHALL equal OUT and gpio_en SHALL equal DIR, driven directly from flops.
REQ-016 Writes to SET/CLR/TGL SHALL update OUT to OUT|d, OUT&~d, OUT^d respectively, taking effect the cycle after bus_req.
REQ-017 Every bus_req SHALL be answered by bus_ack exactly one cycle later; back-to-back requests every cycle SHALL be supported, no stall.
REQ-018 Read data SHALL be registered, zero-extended to 32 bits; wo and reserved indices read 0; writes to IN and reserved indices have no effect.
REQ-019 gpio_in SHALL pass a 2-flop synchronizer; IN reflects a pad change 2 cycles after it is sampled.
REQ-020 Edge detection SHALL compare IN with its 1-cycle-delayed copy; rise = ~prev & cur, fall = prev & ~cur.
REQ-021 PEND[i] SHALL be set the cycle after an edge on bit i whose RISE_EN[i]/FALL_EN[i] is set; pad-to-PEND latency 3 cycles.
REQ-022 Writing 1 to PEND[i] SHALL clear it; writing 0 has no effect.
REQ-023 Simultaneous edge-set and W1C-clear on the same bit in the same cycle: set SHALL win.
REQ-024 Disabling RISE_EN/FALL_EN SHALL NOT clear already-pending bits.
REQ-025 irq SHALL be the OR of PEND, asserted the cycle PEND becomes nonzero, deasserted the cycle after the last bit is cleared.
REQ-026 Direction SHALL NOT gate input sampling: IN and edges reflect pad state, including when the pad is driven.

Reset
REQ-027 On rstn=0, OUT, DIR, RISE_EN, FALL_EN and PEND SHALL be 0, synchronizer and delay flops 0, bus_ack 0, bus_rdata 0, irq 0.
REQ-028 A request in flight when reset asserts SHALL be dropped; no bus_ack after release.
REQ-029 After release, synchronizer flops start at 0: a pad held high SHALL produce a rising edge and set PEND if RISE_EN is enabled.

Structure
REQ-030 Register index constants (OUT..PEND) and the register-count constant SHALL reside in shared package gpio_pkg.
REQ-031 Synchronizer plus edge detector SHALL be sub-module gpio_sync (parameter WIDTH; outputs sync, rise, fall).
REQ-032 gpio_ctrl SHALL contain no tristate; pad tristating stays at the top-level pad wrapper.

Verification
REQ-033 Write OUT=0xA5A5, DIR=0x00FF -> next cycle gpio_out=0xA5A5, gpio_en=0x00FF; reads return same values with bus_ack one cycle after each req.
REQ-034 OUT=0x00F0; SET 0x000F, CLR 0x0030, TGL 0xFFFF on consecutive cycles -> OUT 0x00FF, 0x00CF, 0xFF30.
REQ-035 RISE_EN=0x0001; gpio_in[0] 0->1 at cycle t -> PEND=0x0001 and irq=1 at t+3; W1C 0x0001 -> PEND=0, irq=0 the cycle after ack.
REQ-036 FALL_EN=0x8000; fall on bit 15 timed so the PEND set coincides with W1C 0x8000 -> PEND[15] remains 1.
REQ-037 Read index 3 and index 12 -> bus_rdata=0; write index 2 with 0xFFFF -> IN still follows gpio_in.
REQ-038 Assert rstn low mid-read with OUT=0x1234 -> bus_ack=0, gpio_out=0, gpio_en=0, irq=0 immediately, asynchronously.

Source files
------------

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared constants for the GPIO controller register map.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    // Word-register indices on the core bus
    localparam logic [3:0] c_reg_out     = 4'd0;
    localparam logic [3:0] c_reg_dir     = 4'd1;
    localparam logic [3:0] c_reg_in      = 4'd2;
    localparam logic [3:0] c_reg_set     = 4'd3;
    localparam logic [3:0] c_reg_clr     = 4'd4;
    localparam logic [3:0] c_reg_tgl     = 4'd5;
    localparam logic [3:0] c_reg_rise_en = 4'd6;
    localparam logic [3:0] c_reg_fall_en = 4'd7;
    localparam logic [3:0] c_reg_pend    = 4'd8;

    // Number of implemented indices; everything at or above is reserved
    localparam int unsigned c_reg_count = 9;

    // Core bus data width
    localparam int unsigned c_bus_w = 32;

endpackage
`default_nettype wire

// File: rtl/gpio_sync.sv
`default_nettype none
// ============================================================================
// Module      : gpio_sync
// Description : Two-flop pad synchronizer followed by a one-cycle delayed
//               copy for rise/fall edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_sync #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    // Metastability chain plus previous-value register for edge compare
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= pad;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign sync = r_sync;
    assign rise = r_sync & ~r_prev;
    assign fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_ctrl
// Description : Bus-mapped GPIO controller: output/direction registers,
//               set/clear/toggle aliases, synchronized inputs and
//               per-bit edge interrupts with W1C pending register.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 bus_req,
    input  logic                 bus_we,
    input  logic [3:0]           bus_addr,
    input  logic [c_bus_w-1:0]   bus_wdata,
    output logic [c_bus_w-1:0]   bus_rdata,
    output logic                 bus_ack,
    input  logic [WIDTH-1:0]     gpio_in,
    output logic [WIDTH-1:0]     gpio_out,
    output logic [WIDTH-1:0]     gpio_en,
    output logic                 irq
);

    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_dir;
    logic [WIDTH-1:0]   r_rise_en;
    logic [WIDTH-1:0]   r_fall_en;
    logic [WIDTH-1:0]   r_pend;
    logic               r_ack;
    logic [c_bus_w-1:0] r_rdata;

    logic [WIDTH-1:0]   w_in;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_fall;
    logic [WIDTH-1:0]   w_wdata;
    logic               w_wr;
    logic               w_rd;
    logic [WIDTH-1:0]   w_rd_val;
    logic [c_bus_w-1:0] w_rd_word;
    logic [WIDTH-1:0]   w_pend_set;
    logic [WIDTH-1:0]   w_pend_clr;

    gpio_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .pad  (gpio_in),
        .sync (w_in),
        .rise (w_rise),
        .fall (w_fall)
    );

    assign w_wdata = bus_wdata[WIDTH-1:0];
    assign w_wr    = bus_req &  bus_we;
    assign w_rd    = bus_req & ~bus_we;

    // Upper write-data bits beyond WIDTH carry no meaning
    generate
        if (WIDTH < c_bus_w) begin : g_wdata_hi
            logic w_unused_wdata;
            assign w_unused_wdata = ^bus_wdata[c_bus_w-1:WIDTH];
        end
    endgenerate

    // Read mux; write-only and reserved indices return zero
    always_comb begin
        w_rd_val = '0;
        if (32'(bus_addr) < c_reg_count) begin
            case (bus_addr)
                c_reg_out:     w_rd_val = r_out;
                c_reg_dir:     w_rd_val = r_dir;
                c_reg_in:      w_rd_val = w_in;
                c_reg_rise_en: w_rd_val = r_rise_en;
                c_reg_fall_en: w_rd_val = r_fall_en;
                c_reg_pend:    w_rd_val = r_pend;
                default:       w_rd_val = '0;
            endcase
        end
    end

    // Zero-extend the selected register onto the bus width
    always_comb begin
        w_rd_word              = '0;
        w_rd_word[WIDTH-1:0]   = w_rd_val;
    end

    // Pending set/clear terms; a fresh edge overrides a same-cycle W1C
    always_comb begin
        w_pend_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
        w_pend_clr = '0;
        if (w_wr && bus_addr == c_reg_pend) begin
            w_pend_clr = w_wdata;
        end
    end

    // Bus response: ack every request one cycle later, data only for reads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= bus_req;
            r_rdata <= w_rd ? w_rd_word : '0;
        end
    end

    // Writable control registers including SET/CLR/TGL aliases onto OUT
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            case (bus_addr)
                c_reg_out:     r_out     <= w_wdata;
                c_reg_dir:     r_dir     <= w_wdata;
                c_reg_set:     r_out     <= r_out | w_wdata;
                c_reg_clr:     r_out     <= r_out & ~w_wdata;
                c_reg_tgl:     r_out     <= r_out ^ w_wdata;
                c_reg_rise_en: r_rise_en <= w_wdata;
                c_reg_fall_en: r_fall_en <= w_wdata;
                default:       ;
            endcase
        end
    end

    // Interrupt pending register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
        end
    end

    assign bus_ack   = r_ack;
    assign bus_rdata = r_rdata;
    assign gpio_out  = r_out;
    assign gpio_en   = r_dir;
    assign irq       = |r_pend;

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_ctrl
// Description : Randomized and directed self-checking bench for gpio_ctrl
//               against a register-map reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_ctrl;

    localparam int WIDTH = 16;

    logic              clk;
    logic              rstn;
    logic              bus_req;
    logic              bus_we;
    logic [3:0]        bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ack;
    logic [WIDTH-1:0]  gpio_in;
    logic [WIDTH-1:0]  gpio_out;
    logic [WIDTH-1:0]  gpio_en;
    logic              irq;

    gpio_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_en   (gpio_en),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: architectural registers and the pad samples
    // taken at each clock edge since reset (three leading zeros model the
    // cleared synchronizer after reset release).
    logic [WIDTH-1:0] m_out, m_dir, m_rise, m_fall, m_pend;
    logic             m_ack;
    logic [31:0]      m_rdata;
    logic [WIDTH-1:0] samp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        m_ack = 1'b0; m_rdata = '0;
        samp = '{'0, '0, '0};
    endtask

    // One clock edge of the register map, from pre-edge state and inputs
    task automatic model_edge(input logic req, input logic we, input logic [3:0] addr,
                              input logic [31:0] wd, input logic [WIDTH-1:0] pad);
        logic [WIDTH-1:0] in_now, in_old, d, edges, rdv;
        in_now = samp[$-1];
        in_old = samp[$-2];
        d      = wd[WIDTH-1:0];
        edges  = (in_now & ~in_old & m_rise) | (~in_now & in_old & m_fall);
        rdv    = '0;
        if (req && !we) begin
            case (addr)
                4'd0: rdv = m_out;
                4'd1: rdv = m_dir;
                4'd2: rdv = in_now;
                4'd6: rdv = m_rise;
                4'd7: rdv = m_fall;
                4'd8: rdv = m_pend;
                default: rdv = '0;
            endcase
        end
        m_rdata = {16'h0, rdv};
        m_ack   = req;
        if (req && we && addr == 4'd8) m_pend = m_pend & ~d;
        m_pend = m_pend | edges;
        if (req && we) begin
            case (addr)
                4'd0: m_out  = d;
                4'd1: m_dir  = d;
                4'd3: m_out  = m_out | d;
                4'd4: m_out  = m_out & ~d;
                4'd5: m_out  = m_out ^ d;
                4'd6: m_rise = d;
                4'd7: m_fall = d;
                default: ;
            endcase
        end
        samp.push_back(pad);
        if (samp.size() > 4) void'(samp.pop_front());
    endtask

    task automatic check_all();
        chk("gpio_out",  {16'h0, gpio_out}, {16'h0, m_out});
        chk("gpio_en",   {16'h0, gpio_en},  {16'h0, m_dir});
        chk("irq",       {31'h0, irq},      {31'h0, |m_pend});
        chk("bus_ack",   {31'h0, bus_ack},  {31'h0, m_ack});
        chk("bus_rdata", bus_rdata,         m_rdata);
    endtask

    // Drive one cycle from a negedge, advance model at the edge, check at next negedge
    task automatic step(input logic req, input logic we, input logic [3:0] addr,
                        input logic [31:0] wd, input logic [WIDTH-1:0] pad);
        bus_req = req; bus_we = we; bus_addr = addr; bus_wdata = wd; gpio_in = pad;
        @(posedge clk);
        model_edge(req, we, addr, wd, pad);
        @(negedge clk);
        check_all();
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wd, input logic [WIDTH-1:0] pad);
        step(1'b1, 1'b1, addr, wd, pad);
    endtask

    task automatic rd(input logic [3:0] addr, input logic [WIDTH-1:0] pad);
        step(1'b1, 1'b0, addr, 32'h0, pad);
    endtask

    task automatic idle(input logic [WIDTH-1:0] pad);
        step(1'b0, 1'b0, 4'd0, 32'h0, pad);
    endtask

    logic [WIDTH-1:0] pad;

    initial begin
        rstn = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        gpio_in = '0; pad = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        check_all();

        // Output/direction write and readback
        wr(4'd0, 32'hFFFF_A5A5, pad);
        wr(4'd1, 32'h0000_00FF, pad);
        chk("out_a5a5", {16'h0, gpio_out}, 32'h0000_A5A5);
        chk("en_00ff",  {16'h0, gpio_en},  32'h0000_00FF);
        rd(4'd0, pad);
        chk("rd_out",   bus_rdata, 32'h0000_A5A5);
        rd(4'd1, pad);
        chk("rd_dir",   bus_rdata, 32'h0000_00FF);
        idle(pad);
        chk("ack_idle", {31'h0, bus_ack}, 32'h0);

        // SET / CLR / TGL back-to-back
        wr(4'd0, 32'h00F0, pad);
        wr(4'd3, 32'h000F, pad);
        chk("set", {16'h0, gpio_out}, 32'h00FF);
        wr(4'd4, 32'h0030, pad);
        chk("clr", {16'h0, gpio_out}, 32'h00CF);
        wr(4'd5, 32'hFFFF, pad);
        chk("tgl", {16'h0, gpio_out}, 32'hFF30);

        // Rising edge on bit 0: pending three cycles after the pad change
        wr(4'd6, 32'h0001, pad);
        idle(pad); idle(pad); idle(pad);
        pad[0] = 1'b1;
        idle(pad);
        chk("rise_t1", {31'h0, irq}, 32'h0);
        idle(pad);
        chk("rise_t2", {31'h0, irq}, 32'h0);
        idle(pad);
        chk("rise_t3", {31'h0, irq}, 32'h1);
        wr(4'd8, 32'h0001, pad);
        chk("w1c_irq", {31'h0, irq}, 32'h0);
        idle(pad);
        chk("w1c_irq2", {31'h0, irq}, 32'h0);

        // Falling edge on bit 15 landing on the same edge as its W1C
        wr(4'd6, 32'h0000, pad);
        pad[15] = 1'b1;
        repeat (4) idle(pad);
        wr(4'd7, 32'h8000, pad);
        pad[15] = 1'b0;
        idle(pad);
        idle(pad);
        wr(4'd8, 32'h8000, pad);
        chk("set_wins_irq", {31'h0, irq}, 32'h1);
        rd(4'd8, pad);
        chk("set_wins_pend", bus_rdata, 32'h0000_8000);

        // Write-only / reserved reads and ignored IN write
        rd(4'd3, pad);
        chk("rd_set_zero", bus_rdata, 32'h0);
        rd(4'd12, pad);
        chk("rd_rsvd_zero", bus_rdata, 32'h0);
        wr(4'd2, 32'hFFFF, pad);
        wr(4'd12, 32'hFFFF, pad);
        pad = 16'h5A3C;
        repeat (3) idle(pad);
        rd(4'd2, pad);
        chk("rd_in", bus_rdata, 32'h0000_5A3C);

        // Randomized traffic, pads toggling, back-to-back requests
        for (int i = 0; i < 400; i++) begin
            logic        req, we;
            logic [3:0]  addr;
            logic [31:0] wd;
            req  = ($urandom_range(0, 3) != 0);
            we   = $urandom_range(0, 1) == 1;
            addr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            wd   = $urandom;
            if ($urandom_range(0, 2) == 0) pad = pad ^ 16'($urandom);
            step(req, we, addr, wd, pad);
        end

        // Asynchronous reset in the middle of a read with state loaded
        wr(4'd0, 32'h1234, pad);
        wr(4'd1, 32'hFFFF, pad);
        wr(4'd7, 32'hFFFF, pad);
        pad = '0;
        repeat (4) idle(pad);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 4'd0;
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_ack",  {31'h0, bus_ack},  32'h0);
        chk("arst_out",  {16'h0, gpio_out}, 32'h0);
        chk("arst_en",   {16'h0, gpio_en},  32'h0);
        chk("arst_irq",  {31'h0, irq},      32'h0);
        chk("arst_rd",   bus_rdata,         32'h0);
        bus_req = 1'b0;
        model_reset();
        pad = 16'hFFFF;
        gpio_in = pad;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        check_all();

        // Pad held high through reset yields a rising edge after release
        wr(4'd6, 32'h0003, pad);
        chk("no_stale_ack_rdata", bus_rdata, 32'h0);
        idle(pad);
        idle(pad);
        chk("post_rst_rise_irq", {31'h0, irq}, 32'h1);
        rd(4'd8, pad);
        chk("post_rst_pend", bus_rdata, 32'h0000_0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
